// File: rtl/mdu_dispatch_pkg.sv
// Shared definitions for the multi-lane MDU dispatcher.
//   - RISC-V M-extension funct3 encodings
//   - result-register state encoding
//   - width helpers for lane indices and occupancy counters
package mdu_dispatch_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        RES_EMPTY = 2'd0,
        RES_LOAD  = 2'd1,
        RES_HOLD  = 2'd2
    } res_state_e;

    // Index width for n items; never narrower than one bit.
    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must reach the value n inclusive.
    function automatic int occ_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mdu_dispatch_unit_fifo.sv
// mdu_tag_fifo: small synchronous FIFO holding the lane index of every
// outstanding operation in issue order.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, data_i    write a tag (ignored when full)
//   pop_i             drop the head tag (ignored when empty)
//   full_o, empty_o   occupancy flags
//   head_o            oldest stored tag
module mdu_tag_fifo
    import mdu_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = lane_idx_w(DEPTH);
    localparam int CW = occ_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mdu_dispatch_unit.sv
// mdu_dispatch_unit: fans one core-side MDU interface out to NUM_LANES
// mdu_macro lanes. Ops go round-robin to free lanes, their lane index is
// queued in issue order, and results are returned to the core strictly in
// that order through a single result register.
// Ports:
//   core_*            core request/response handshake (start/busy, done/ack)
//   lane_start/ack    per-lane request and consume pulses
//   lane_funct3/operand_a/operand_b   per-lane operand registers
//   lane_busy         lane status, monitored only
//   lane_done/product/quotient/remainder   per-lane results
// Optional build macro: MDU_RESULT_CACHE_EN adds a one-entry cache of the
// last acknowledged op; a matching request on an idle unit is answered
// from the cache without dispatching a lane.
module mdu_dispatch_unit
    import mdu_dispatch_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_start,
    input  logic [2:0]              core_funct3,
    input  logic [31:0]             core_operand_a,
    input  logic [31:0]             core_operand_b,
    output logic                    core_busy,
    output logic                    core_done,
    input  logic                    core_ack,
    output logic [63:0]             core_product,
    output logic [31:0]             core_quotient,
    output logic [31:0]             core_remainder,
    output logic [NUM_LANES-1:0]    lane_start,
    output logic [3*NUM_LANES-1:0]  lane_funct3,
    output logic [32*NUM_LANES-1:0] lane_operand_a,
    output logic [32*NUM_LANES-1:0] lane_operand_b,
    output logic [NUM_LANES-1:0]    lane_ack,
    input  logic [NUM_LANES-1:0]    lane_busy,
    input  logic [NUM_LANES-1:0]    lane_done,
    input  logic [64*NUM_LANES-1:0] lane_product,
    input  logic [32*NUM_LANES-1:0] lane_quotient,
    input  logic [32*NUM_LANES-1:0] lane_remainder
);

    localparam int LANE_W = lane_idx_w(NUM_LANES);

    res_state_e              state_q;
    logic                    done_q;
    logic [63:0]             product_q;
    logic [31:0]             quotient_q, remainder_q;
    logic [NUM_LANES-1:0]    pending_q, pending_d, lane_start_q;
    logic [LANE_W-1:0]       rr_ptr_q, rr_ptr_d, sel, head_tag;
    logic [3*NUM_LANES-1:0]  lane_funct3_q;
    logic [32*NUM_LANES-1:0] lane_a_q, lane_b_q;
    logic                    fifo_full, fifo_empty;
    logic                    accept, dispatch, pop, cache_hit, res_from_cache;
    logic                    found;
    int                      idx;

    // Lane status is informational only; selection uses the pending mask.
    logic unused_lane_busy;
    assign unused_lane_busy = ^lane_busy;

    assign core_busy      = (&pending_q) | fifo_full;
    assign accept         = core_start & ~core_busy;
    assign dispatch       = accept & ~cache_hit;
    assign pop            = (state_q == RES_HOLD) & core_ack & ~res_from_cache;
    assign core_done      = done_q;
    assign core_product   = product_q;
    assign core_quotient  = quotient_q;
    assign core_remainder = remainder_q;
    assign lane_start     = lane_start_q;
    assign lane_funct3    = lane_funct3_q;
    assign lane_operand_a = lane_a_q;
    assign lane_operand_b = lane_b_q;

    // First free lane at or after the round-robin pointer, wrapping.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_LANES;
            if (!found && !pending_q[idx[LANE_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[LANE_W-1:0];
            end
        end
    end

    // The consume pulse reaches the head lane in the same cycle as core_ack,
    // so the lane only becomes selectable again on the following cycle.
    always_comb begin
        lane_ack = '0;
        if (pop) lane_ack[head_tag] = 1'b1;
    end

    always_comb begin
        pending_d = pending_q & ~lane_ack;
        if (dispatch) pending_d[sel] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (dispatch) rr_ptr_d = (sel == LANE_W'(NUM_LANES - 1)) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            lane_start_q  <= '0;
            lane_funct3_q <= '0;
            lane_a_q      <= '0;
            lane_b_q      <= '0;
        end else begin
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            lane_start_q <= '0;
            if (dispatch) begin
                lane_start_q[sel]                 <= 1'b1;
                lane_funct3_q[3*int'(sel) +: 3]   <= core_funct3;
                lane_a_q[32*int'(sel) +: 32]      <= core_operand_a;
                lane_b_q[32*int'(sel) +: 32]      <= core_operand_b;
            end
        end
    end

    mdu_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (LANE_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (dispatch),
        .data_i  (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_tag)
    );

`ifdef MDU_RESULT_CACHE_EN
    logic        cache_vld_q, from_cache_q;
    logic [2:0]  cache_f3_q;
    logic [31:0] cache_a_q, cache_b_q, cache_quot_q, cache_rem_q;
    logic [63:0] cache_prod_q;

    // Only an idle unit may answer from the cache, so ordering is preserved.
    assign cache_hit = cache_vld_q && fifo_empty && (state_q == RES_EMPTY)
                    && (core_funct3 == cache_f3_q)
                    && (core_operand_a == cache_a_q)
                    && (core_operand_b == cache_b_q);
    assign res_from_cache = from_cache_q;

    // The head lane's operand registers still hold the op being acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_q  <= 1'b0;
            cache_f3_q   <= '0;
            cache_a_q    <= '0;
            cache_b_q    <= '0;
            cache_prod_q <= '0;
            cache_quot_q <= '0;
            cache_rem_q  <= '0;
        end else if (pop) begin
            cache_vld_q  <= 1'b1;
            cache_f3_q   <= lane_funct3_q[3*int'(head_tag) +: 3];
            cache_a_q    <= lane_a_q[32*int'(head_tag) +: 32];
            cache_b_q    <= lane_b_q[32*int'(head_tag) +: 32];
            cache_prod_q <= product_q;
            cache_quot_q <= quotient_q;
            cache_rem_q  <= remainder_q;
        end
    end
`else
    assign cache_hit      = 1'b0;
    assign res_from_cache = 1'b0;
`endif

    // Result register: EMPTY captures the head result, LOAD raises
    // core_done, HOLD waits for the core to consume it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RES_EMPTY;
            done_q      <= 1'b0;
            product_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef MDU_RESULT_CACHE_EN
            from_cache_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                RES_EMPTY: begin
`ifdef MDU_RESULT_CACHE_EN
                    if (accept && cache_hit) begin
                        product_q    <= cache_prod_q;
                        quotient_q   <= cache_quot_q;
                        remainder_q  <= cache_rem_q;
                        from_cache_q <= 1'b1;
                        state_q      <= RES_LOAD;
                    end else
`endif
                    if (!fifo_empty && lane_done[head_tag]) begin
                        product_q   <= lane_product[64*int'(head_tag) +: 64];
                        quotient_q  <= lane_quotient[32*int'(head_tag) +: 32];
                        remainder_q <= lane_remainder[32*int'(head_tag) +: 32];
`ifdef MDU_RESULT_CACHE_EN
                        from_cache_q <= 1'b0;
`endif
                        state_q     <= RES_LOAD;
                    end
                end
                RES_LOAD: begin
                    state_q <= RES_HOLD;
                    done_q  <= 1'b1;
                end
                RES_HOLD: begin
                    if (core_ack) begin
                        state_q <= RES_EMPTY;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= RES_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_dispatch_unit.sv
// Directed bench for mdu_dispatch_unit with two behavioural lane models
// whose latency is set per lane by each scenario.
module tb_mdu_dispatch_unit;
    import mdu_dispatch_pkg::*;

    localparam int N = 2;

    logic          clk, rst_n;
    logic          core_start, core_busy, core_done, core_ack;
    logic [2:0]    core_funct3;
    logic [31:0]   core_operand_a, core_operand_b, core_quotient, core_remainder;
    logic [63:0]   core_product;
    logic [N-1:0]  lane_start, lane_ack, lane_busy, lane_done;
    logic [3*N-1:0]  lane_funct3;
    logic [32*N-1:0] lane_operand_a, lane_operand_b, lane_quotient, lane_remainder;
    logic [64*N-1:0] lane_product;

    int vec_cnt = 0;
    int fail_cnt = 0;

    mdu_dispatch_unit #(.NUM_LANES(N), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_start(core_start), .core_funct3(core_funct3),
        .core_operand_a(core_operand_a), .core_operand_b(core_operand_b),
        .core_busy(core_busy), .core_done(core_done), .core_ack(core_ack),
        .core_product(core_product), .core_quotient(core_quotient),
        .core_remainder(core_remainder),
        .lane_start(lane_start), .lane_funct3(lane_funct3),
        .lane_operand_a(lane_operand_a), .lane_operand_b(lane_operand_b),
        .lane_ack(lane_ack), .lane_busy(lane_busy), .lane_done(lane_done),
        .lane_product(lane_product), .lane_quotient(lane_quotient),
        .lane_remainder(lane_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- lane models ----
    int          lat [N];
    logic [2:0]  m_f3 [N];
    logic [31:0] m_a [N], m_b [N], m_quo [N], m_rem [N];
    logic [63:0] m_prod [N];
    int          m_cnt [N];
    logic        m_run [N], m_done [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_run[i] <= 1'b0; m_done[i] <= 1'b0; m_cnt[i] <= 0;
                m_prod[i] <= '0; m_quo[i] <= '0; m_rem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (lane_ack[i]) m_done[i] <= 1'b0;
                if (lane_start[i]) begin
                    m_run[i] <= 1'b1;
                    m_cnt[i] <= lat[i];
                    m_f3[i]  <= lane_funct3[3*i +: 3];
                    m_a[i]   <= lane_operand_a[32*i +: 32];
                    m_b[i]   <= lane_operand_b[32*i +: 32];
                end else if (m_run[i]) begin
                    if (m_cnt[i] <= 1) begin
                        m_run[i]  <= 1'b0;
                        m_done[i] <= 1'b1;
                        if (m_f3[i] == F3_DIV) begin
                            m_prod[i] <= '0;
                            m_quo[i]  <= m_a[i] / m_b[i];
                            m_rem[i]  <= m_a[i] % m_b[i];
                        end else begin
                            m_prod[i] <= {32'b0, m_a[i]} * {32'b0, m_b[i]};
                            m_quo[i]  <= '0;
                            m_rem[i]  <= '0;
                        end
                    end else begin
                        m_cnt[i] <= m_cnt[i] - 1;
                    end
                end
            end
        end
    end

    always_comb begin
        lane_done = '0; lane_busy = '0; lane_product = '0;
        lane_quotient = '0; lane_remainder = '0;
        for (int i = 0; i < N; i++) begin
            lane_done[i] = m_done[i];
            lane_busy[i] = m_run[i];
            lane_product[64*i +: 64]   = m_prod[i];
            lane_quotient[32*i +: 32]  = m_quo[i];
            lane_remainder[32*i +: 32] = m_rem[i];
        end
    end

    // ---- monitors ----
    int start_cnt = 0;
    int ack_cnt [N];
    int lane_hist [$];

    initial for (int i = 0; i < N; i++) ack_cnt[i] = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (lane_start[i]) begin
                    start_cnt <= start_cnt + 1;
                    lane_hist.push_back(i);
                end
                if (lane_ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- helpers ----
    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        core_start = s; core_funct3 = f; core_operand_a = a; core_operand_b = b;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; core_ack = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (core_done !== 1'b1 && n < budget) begin step; n++; end
        vec_cnt++;
        if (core_done !== 1'b1) begin
            fail_cnt++;
            $display("FAIL %s: core_done=%b after %0d cycles, required 1", name, core_done, budget);
        end
    endtask

    task automatic do_ack;
        core_ack = 1'b1; step; core_ack = 1'b0;
    endtask

    // ---- scenarios ----
    task automatic test_reset;
        rst_n = 1'b0; core_ack = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(posedge clk); #1;
        vec_cnt++;
        if ({core_busy, core_done, lane_start, lane_ack} !== 6'b0) begin
            fail_cnt++;
            $display("FAIL reset_ctrl: got %b, want 000000", {core_busy, core_done, lane_start, lane_ack});
        end
        vec_cnt++;
        if ({lane_funct3, lane_operand_a, lane_operand_b} !== '0) begin
            fail_cnt++;
            $display("FAIL reset_lane_regs: got %h, want 0", {lane_funct3, lane_operand_a, lane_operand_b});
        end
        vec_cnt++;
        if ({core_product, core_quotient, core_remainder} !== 128'd0) begin
            fail_cnt++;
            $display("FAIL reset_result: got %h, want 0", {core_product, core_quotient, core_remainder});
        end
        rst_n = 1'b1; step;
    endtask

    task automatic test_single_op;
        int a0;
        do_reset; lat[0] = 3; lat[1] = 3; a0 = ack_cnt[0];
        drive(1'b1, F3_MUL, 32'd7, 32'd6);
        vec_cnt++;
        if (core_busy !== 1'b0) begin fail_cnt++; $display("FAIL single_busy: got %b, want 0", core_busy); end
        step; core_start = 1'b0;
        vec_cnt++;
        if (lane_start !== 2'b01 || lane_operand_b[31:0] !== 32'd6) begin
            fail_cnt++; $display("FAIL single_lane_start: got %b/%0d, want 01/6", lane_start, lane_operand_b[31:0]);
        end
        wait_done(30, "single_done");
        vec_cnt++;
        if (core_product !== 64'd42) begin fail_cnt++; $display("FAIL single_product: got %0d, want 42", core_product); end
        core_ack = 1'b1; #1;
        vec_cnt++;
        if (lane_ack !== 2'b01) begin fail_cnt++; $display("FAIL single_lane_ack: got %b, want 01", lane_ack); end
        step; core_ack = 1'b0;
        vec_cnt++;
        if (core_done !== 1'b0 || lane_ack !== 2'b00) begin
            fail_cnt++; $display("FAIL single_done_fall: got done=%b ack=%b, want 0/00", core_done, lane_ack);
        end
        repeat (3) step;
        vec_cnt++;
        if (ack_cnt[0] - a0 !== 1) begin fail_cnt++; $display("FAIL single_ack_count: got %0d, want 1", ack_cnt[0] - a0); end
`ifdef MDU_RESULT_CACHE_EN
        begin
            int s0;
            s0 = start_cnt;
            drive(1'b1, F3_MUL, 32'd7, 32'd6);
            step; core_start = 1'b0;
            vec_cnt++;
            if (lane_start !== 2'b00 || core_done !== 1'b0) begin
                fail_cnt++; $display("FAIL cache_t1: got start=%b done=%b, want 00/0", lane_start, core_done);
            end
            step;
            vec_cnt++;
            if (core_done !== 1'b1 || core_product !== 64'd42) begin
                fail_cnt++; $display("FAIL cache_t2: got done=%b prod=%0d, want 1/42", core_done, core_product);
            end
            do_ack; repeat (2) step;
            vec_cnt++;
            if (start_cnt != s0) begin fail_cnt++; $display("FAIL cache_no_dispatch: got %0d starts, want 0", start_cnt - s0); end
        end
`endif
    endtask

    task automatic test_out_of_order;
        do_reset; lat[0] = 20; lat[1] = 2;
        drive(1'b1, F3_DIV, 32'd100, 32'd7); step;
        vec_cnt++;
        if (lane_start !== 2'b01) begin fail_cnt++; $display("FAIL ooo_div_lane: got %b, want 01", lane_start); end
        drive(1'b1, F3_MUL, 32'd3, 32'd5); step; core_start = 1'b0;
        vec_cnt++;
        if (lane_start !== 2'b10) begin fail_cnt++; $display("FAIL ooo_mul_lane: got %b, want 10", lane_start); end
        wait_done(60, "ooo_first_done");
        vec_cnt++;
        if (core_quotient !== 32'd14 || core_remainder !== 32'd2) begin
            fail_cnt++; $display("FAIL ooo_div_result: got q=%0d r=%0d, want 14/2", core_quotient, core_remainder);
        end
        vec_cnt++;
        if (lane_done !== 2'b11) begin fail_cnt++; $display("FAIL ooo_younger_held: got %b, want 11", lane_done); end
        do_ack;
        wait_done(20, "ooo_second_done");
        vec_cnt++;
        if (core_product !== 64'd15) begin fail_cnt++; $display("FAIL ooo_mul_result: got %0d, want 15", core_product); end
        do_ack;
    endtask

    task automatic test_back_pressure;
        int s0;
        do_reset; lat[0] = 4; lat[1] = 4; s0 = start_cnt;
        drive(1'b1, F3_MUL, 32'd2, 32'd5); step;
        vec_cnt++;
        if (core_busy !== 1'b0) begin fail_cnt++; $display("FAIL bp_busy_1: got %b, want 0", core_busy); end
        drive(1'b1, F3_MUL, 32'd3, 32'd4); step;
        vec_cnt++;
        if (core_busy !== 1'b1) begin fail_cnt++; $display("FAIL bp_busy_2: got %b, want 1", core_busy); end
        drive(1'b1, F3_MUL, 32'd6, 32'd6); step; core_start = 1'b0;
        vec_cnt++;
        if (lane_start !== 2'b00) begin fail_cnt++; $display("FAIL bp_third_ignored: got %b, want 00", lane_start); end
        step;
        vec_cnt++;
        if (start_cnt - s0 !== 2) begin fail_cnt++; $display("FAIL bp_start_count: got %0d, want 2", start_cnt - s0); end
        wait_done(30, "bp_done_1");
        vec_cnt++;
        if (core_product !== 64'd10) begin fail_cnt++; $display("FAIL bp_result_1: got %0d, want 10", core_product); end
        // start together with ack while both lanes are pending
        drive(1'b1, F3_MUL, 32'd9, 32'd9); core_ack = 1'b1; #1;
        vec_cnt++;
        if (core_busy !== 1'b1) begin fail_cnt++; $display("FAIL bp_reuse_busy: got %b, want 1", core_busy); end
        step; core_ack = 1'b0;
        vec_cnt++;
        if (lane_start !== 2'b00 || core_busy !== 1'b0) begin
            fail_cnt++; $display("FAIL bp_reuse_next: got start=%b busy=%b, want 00/0", lane_start, core_busy);
        end
        step; core_start = 1'b0;
        vec_cnt++;
        if (lane_start !== 2'b01) begin fail_cnt++; $display("FAIL bp_reuse_lane: got %b, want 01", lane_start); end
        wait_done(30, "bp_done_2");
        vec_cnt++;
        if (core_product !== 64'd12) begin fail_cnt++; $display("FAIL bp_result_2: got %0d, want 12", core_product); end
        do_ack;
        wait_done(30, "bp_done_3");
        vec_cnt++;
        if (core_product !== 64'd81) begin fail_cnt++; $display("FAIL bp_result_3: got %0d, want 81", core_product); end
        do_ack;
    endtask

    task automatic test_round_robin;
        int h;
        int exp_lane [4] = '{0, 1, 0, 1};
        logic [63:0] exp_prod [4] = '{64'd11, 64'd24, 64'd39, 64'd56};
        do_reset; lat[0] = 2; lat[1] = 2; h = lane_hist.size();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, F3_MUL, 32'(k + 1), 32'(k + 11)); step; core_start = 1'b0;
            wait_done(20, "rr_done");
            vec_cnt++;
            if (core_product !== exp_prod[k]) begin
                fail_cnt++; $display("FAIL rr_product_%0d: got %0d, want %0d", k, core_product, exp_prod[k]);
            end
            do_ack;
        end
        vec_cnt++;
        if (lane_hist.size() - h !== 4) begin fail_cnt++; $display("FAIL rr_count: got %0d, want 4", lane_hist.size() - h); end
        else begin
            for (int k = 0; k < 4; k++) begin
                vec_cnt++;
                if (lane_hist[h + k] !== exp_lane[k]) begin
                    fail_cnt++; $display("FAIL rr_lane_%0d: got %0d, want %0d", k, lane_hist[h + k], exp_lane[k]);
                end
            end
        end
    endtask

    task automatic test_simul_start_ack;
        do_reset; lat[0] = 3; lat[1] = 3;
        drive(1'b1, F3_MUL, 32'd2, 32'd3); step; core_start = 1'b0;
        wait_done(20, "sim_done_1");
        vec_cnt++;
        if (core_product !== 64'd6) begin fail_cnt++; $display("FAIL sim_result_1: got %0d, want 6", core_product); end
        drive(1'b1, F3_MUL, 32'd4, 32'd5); core_ack = 1'b1; #1;
        vec_cnt++;
        if (core_busy !== 1'b0 || lane_ack !== 2'b01) begin
            fail_cnt++; $display("FAIL sim_both: got busy=%b ack=%b, want 0/01", core_busy, lane_ack);
        end
        step; core_start = 1'b0; core_ack = 1'b0;
        vec_cnt++;
        if (lane_start !== 2'b10 || core_done !== 1'b0) begin
            fail_cnt++; $display("FAIL sim_dispatch: got start=%b done=%b, want 10/0", lane_start, core_done);
        end
        wait_done(20, "sim_done_2");
        vec_cnt++;
        if (core_product !== 64'd20) begin fail_cnt++; $display("FAIL sim_result_2: got %0d, want 20", core_product); end
        do_ack;
        repeat (6) step;
        vec_cnt++;
        if (core_done !== 1'b0) begin fail_cnt++; $display("FAIL sim_fifo_drained: got done=%b, want 0", core_done); end
    endtask

    task automatic test_reset_midop;
        do_reset; lat[0] = 8; lat[1] = 8;
        drive(1'b1, F3_DIV, 32'd100, 32'd7); step;
        drive(1'b1, F3_DIV, 32'd50, 32'd3); step; core_start = 1'b0;
        vec_cnt++;
        if (core_busy !== 1'b1 || lane_start !== 2'b10) begin
            fail_cnt++; $display("FAIL rst_pre: got busy=%b start=%b, want 1/10", core_busy, lane_start);
        end
        rst_n = 1'b0; #1;
        vec_cnt++;
        if ({core_busy, core_done, lane_start, lane_ack} !== 6'b0) begin
            fail_cnt++; $display("FAIL rst_async: got %b, want 000000", {core_busy, core_done, lane_start, lane_ack});
        end
        step; rst_n = 1'b1; step;
        lat[0] = 3;
        drive(1'b1, F3_MUL, 32'd7, 32'd6); step; core_start = 1'b0;
        wait_done(20, "rst_hold_done");
        core_ack = 1'b1; #1;
        rst_n = 1'b0; #1;
        vec_cnt++;
        if (lane_ack !== 2'b00 || core_done !== 1'b0) begin
            fail_cnt++; $display("FAIL rst_in_hold: got ack=%b done=%b, want 00/0", lane_ack, core_done);
        end
        core_ack = 1'b0; step; rst_n = 1'b1; step;
        drive(1'b1, F3_MUL, 32'd2, 32'd2); step; core_start = 1'b0;
        wait_done(20, "rst_after_done");
        vec_cnt++;
        if (core_product !== 64'd4) begin fail_cnt++; $display("FAIL rst_clean_result: got %0d, want 4", core_product); end
        do_ack;
    endtask

    initial begin
        rst_n = 1'b0; core_ack = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        lat[0] = 3; lat[1] = 3;
        test_reset;
        test_single_op;
        test_out_of_order;
        test_back_pressure;
        test_round_robin;
        test_simul_start_ack;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
